rom_streamer: RTL and testbench

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer.sv | 120 ++++++++++++
 tb/tb_rom_streamer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rom_streamer.sv
// Streams a run of consecutive words from a combinational ROM onto a valid/ready
// output, one word per cycle while downstream keeps up, then pulses oDone.
module rom_streamer #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [ADDRWIDTH-1:0] iStartAddr,
  input  logic [ADDRWIDTH:0]   iLength,
  output logic [ADDRWIDTH-1:0] oRomAddress,
  input  logic [DATAWIDTH-1:0] iRomData,
  output logic [DATAWIDTH-1:0] oData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oBusy,
  output logic                 oDone
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDRWIDTH-1:0] ADDR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDRWIDTH:0]   REM_ONE  = {{ADDRWIDTH{1'b0}}, 1'b1};

  state_t                 r_state,     w_state_nxt;
  logic [ADDRWIDTH-1:0]   r_addr,      w_addr_nxt;
  logic [ADDRWIDTH:0]     r_remaining, w_remaining_nxt;
  logic [DATAWIDTH-1:0]   r_data,      w_data_nxt;
  logic                   r_valid,     w_valid_nxt;
  logic                   r_busy,      w_busy_nxt;
  logic                   r_done,      w_done_nxt;
  logic                   w_can_advance;
  logic                   w_load;

  // The output slot can take a new word when it is empty or being drained this cycle.
  assign w_can_advance = !r_valid || iReady;
  assign w_load        = (r_remaining != '0) && w_can_advance;

  assign oRomAddress = r_addr;
  assign oData       = r_data;
  assign oValid      = r_valid;
  assign oBusy       = r_busy;
  assign oDone       = r_done;

  // State register and datapath registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; oBusy/oDone are computed one cycle ahead
  // so they come straight out of flops yet line up with the FSM state.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    w_data_nxt      = r_data;
    w_valid_nxt     = r_valid;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_addr_nxt      = iStartAddr;
          w_remaining_nxt = iLength;
          w_state_nxt     = S_RUN;
          w_busy_nxt      = 1'b1;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_RUN: begin
        w_busy_nxt = 1'b1;
        if (w_load) begin
          w_data_nxt      = iRomData;
          w_valid_nxt     = 1'b1;
          w_addr_nxt      = r_addr + ADDR_ONE;
          w_remaining_nxt = r_remaining - REM_ONE;
        end else if (w_can_advance) begin
          // Nothing left to load and the slot is empty or draining: burst complete.
          w_valid_nxt = 1'b0;
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_valid_nxt = r_valid;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_streamer.sv
// Drives rom_streamer with directed and random bursts and checks every accepted
// word, burst timing and reset behaviour against an expected-word queue.
module tb_rom_streamer;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iStart;
  logic [3:0] iStartAddr;
  logic [4:0] iLength;
  logic [3:0] oRomAddress;
  logic [7:0] iRomData;
  logic [7:0] oData;
  logic       oValid;
  logic       iReady;
  logic       oBusy;
  logic       oDone;

  logic [7:0] mem [16];
  int total = 0;
  int bad   = 0;

  assign iRomData = mem[oRomAddress];

  always #5 iClk = ~iClk;

  rom_streamer #(.ADDRWIDTH(4), .DATAWIDTH(8)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iStartAddr(iStartAddr),
    .iLength(iLength), .oRomAddress(oRomAddress), .iRomData(iRomData),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oBusy(oBusy), .oDone(oDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: iReady held 1; mode 1: iReady pattern 1,0,0,1; mode 2: random iReady.
  // restart_at / rst_at: cycle (counted from the edge that samples iStart) at
  // which to re-pulse iStart or assert iRst; 0 disables.
  task automatic run_burst(input logic [3:0] sa, input logic [4:0] len, input int mode,
                           input int restart_at, input int rst_at);
    logic [7:0] exp_q [$];
    logic [7:0] w;
    logic [3:0] end_addr;
    int first_valid = 0, first_acc = 0, last_acc = 0, done_cyc = 0;
    int done_cnt = 0, busy_cnt = 0, acc_cnt = 0;
    bit valid_seen = 1'b0, aborted = 1'b0;
    for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[4'((int'(sa) + i) % 16)]);
    end_addr = sa + len[3:0];
    @(negedge iClk);
    iStart = 1'b1; iStartAddr = sa; iLength = len;
    iReady = (mode == 0) ? 1'b1 : 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge iClk);
      iStart = (cyc == restart_at);
      if (cyc == restart_at) begin
        iStartAddr = ~sa; iLength = 5'd3;
      end
      if (aborted) begin
        chk("reset_outputs", {oValid, oBusy, oDone, oRomAddress, oData}, 32'd0);
        iRst = 1'b0;
        break;
      end
      if (oBusy) busy_cnt++;
      if (oDone) begin done_cnt++; done_cyc = cyc; end
      if (oValid && !valid_seen) begin valid_seen = 1'b1; first_valid = cyc; end
      if (cyc == rst_at) begin
        iRst = 1'b1; iStart = 1'b1; iReady = 1'b1; aborted = 1'b1;
        continue;
      end
      case (mode)
        0:       iReady = 1'b1;
        1:       iReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: iReady = 1'($urandom_range(0, 1));
      endcase
      if (oValid && iReady) begin
        acc_cnt++;
        if (first_acc == 0) first_acc = cyc;
        last_acc = cyc;
        if (exp_q.size() == 0) chk("word_count", acc_cnt, len);
        else begin
          w = exp_q.pop_front();
          chk("data", oData, w);
        end
      end
      if (!oBusy && cyc > 1) break;
    end
    iStart = 1'b0;
    if (aborted) begin
      chk("no_done_on_abort", done_cnt, 0);
      @(negedge iClk);
      chk("idle_after_abort", {oBusy, oDone, oValid}, 3'b000);
    end else begin
      chk("burst_ended", oBusy, 1'b0);
      chk("words_missing", exp_q.size(), 0);
      chk("xfers", acc_cnt, len);
      chk("done_pulses", done_cnt, 1);
      chk("valid_seen", valid_seen, (len != 5'd0));
      chk("end_addr", oRomAddress, end_addr);
      if (mode == 0) begin
        if (len != 5'd0) begin
          chk("first_latency", first_valid, 2);
          chk("throughput", last_acc - first_acc, int'(len) - 1);
        end
        chk("done_time", done_cyc, int'(len) + 2);
        chk("busy_cycles", busy_cnt, int'(len) + 2);
      end
      iReady = 1'($urandom_range(0, 1));
      @(negedge iClk);
      @(negedge iClk);
      chk("idle_hold", {oBusy, oDone, oRomAddress}, {2'b00, end_addr});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    iRst = 1'b1; iStart = 1'b1; iStartAddr = 4'd7; iLength = 5'd5; iReady = 1'b1;
    repeat (3) @(negedge iClk);
    chk("reset_state", {oValid, oBusy, oDone, oRomAddress, oData}, 32'd0);
    iRst = 1'b0; iStart = 1'b0;
    @(negedge iClk);
    chk("idle_no_start", {oBusy, oValid, oRomAddress}, 6'd0);

    run_burst(4'd2,  5'd4,  0, 0, 0);   // 12,13,14,15
    run_burst(4'd14, 5'd4,  0, 0, 0);   // 1E,1F,10,11 across the wrap
    run_burst(4'd5,  5'd4,  1, 0, 0);   // backpressure pattern
    run_burst(4'd9,  5'd0,  0, 0, 0);   // empty burst
    run_burst(4'd0,  5'd16, 0, 6, 0);   // full ROM, iStart re-pulsed mid-burst
    run_burst(4'd3,  5'd8,  0, 0, 4);   // reset after second word
    run_burst(4'd11, 5'd8,  0, 0, 0);   // fresh burst after the abort
    for (int n = 0; n < 8; n++)
      run_burst(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)), 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
